// File: rtl/cpu_controller.sv
// Instruction register, decoder and control FSM feeding the datapath.
// Controls are Moore outputs decoded from the registered state and IR.
module cpu_controller #(
    parameter logic [15:0] IR_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [1:0]  vsel,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StWriteImm,
        StGetA,
        StGetB,
        StAlu,
        StWriteReg
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  nsel;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;
    logic       is_mov_imm, is_mov_reg, is_mvn, is_cmp, is_alu_ab;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
    // ADD, CMP and AND read Rn through A; MOV reg and MVN zero A instead.
    assign is_alu_ab  = (opcode == 3'b101) && (op != 2'b11);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StWait;
            ir_q    <= IR_RESET;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        ir_d = ir_q;
        if (load && (state_q == StWait)) begin
            ir_d = in;
        end
    end

    always_comb begin
        state_d = state_q;
        w       = 1'b0;
        vsel    = 2'b00;
        write   = 1'b0;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        nsel    = rm;
        case (state_q)
            StWait: begin
                w = 1'b1;
                if (s) state_d = StDecode;
            end
            StDecode: begin
                if (is_mov_imm)                 state_d = StWriteImm;
                else if (is_mov_reg || is_mvn)  state_d = StGetB;
                else if (is_alu_ab)             state_d = StGetA;
                else                            state_d = StWait;
            end
            StWriteImm: begin
                nsel    = rn;
                vsel    = 2'b01;
                write   = 1'b1;
                state_d = StWait;
            end
            StGetA: begin
                nsel    = rn;
                loada   = 1'b1;
                state_d = StGetB;
            end
            StGetB: begin
                nsel    = rm;
                loadb   = 1'b1;
                state_d = StAlu;
            end
            StAlu: begin
                asel = is_mov_reg || is_mvn;
                if (is_cmp) begin
                    loads   = 1'b1;
                    state_d = StWait;
                end else begin
                    loadc   = 1'b1;
                    state_d = StWriteReg;
                end
            end
            StWriteReg: begin
                nsel    = rd;
                vsel    = 2'b11;
                write   = 1'b1;
                state_d = StWait;
            end
            default: state_d = StWait;
        endcase
    end

    assign bsel     = 1'b0;
    assign readnum  = nsel;
    assign writenum = nsel;
    assign shift    = ir_q[4:3];
    // MOV reg has op=00, so IR[12:11] already yields the 0 + shifted Rm operation.
    assign ALUop    = ir_q[12:11];
    assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized self-checking bench for cpu_controller against a per-instruction
// micro-step model built from the instruction's class.
module tb_cpu_controller;

    logic        clk;
    logic        reset_n;
    logic [15:0] in_t;
    logic        load_t;
    logic        s_t;
    logic        w;
    logic [1:0]  vsel;
    logic        write;
    logic        loada, loadb, loadc, loads;
    logic        asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, alu_op;
    logic [15:0] sximm8, sximm5;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [19:0] exp_q[$];

    cpu_controller #(.IR_RESET(16'h0000)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (in_t),
        .load     (load_t),
        .s        (s_t),
        .w        (w),
        .vsel     (vsel),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .readnum  (readnum),
        .writenum (writenum),
        .shift    (shift),
        .ALUop    (alu_op),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] observe();
        return {w, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                readnum, writenum, shift, alu_op};
    endfunction

    function automatic logic [19:0] mk(input logic we, input logic [1:0] vs, input logic wr,
                                       input logic la, input logic lb, input logic lc,
                                       input logic ls, input logic as, input logic [2:0] num,
                                       input logic [15:0] ir);
        return {we, vs, wr, la, lb, lc, ls, as, 1'b0, num, num, ir[4:3], ir[12:11]};
    endfunction

    // One expected control vector per clock from DECODE until just before WAIT.
    function automatic void build(input logic [15:0] ir);
        logic [2:0] oc, rn, rd, rm;
        logic [1:0] op;
        bit mov_imm, mov_reg, mvn, cmp, add_and;
        oc = ir[15:13]; op = ir[12:11];
        rn = ir[10:8];  rd = ir[7:5]; rm = ir[2:0];
        mov_imm = (oc == 3'd6) && (op == 2'd2);
        mov_reg = (oc == 3'd6) && (op == 2'd0);
        mvn     = (oc == 3'd5) && (op == 2'd3);
        cmp     = (oc == 3'd5) && (op == 2'd1);
        add_and = (oc == 3'd5) && (op == 2'd0 || op == 2'd2);
        exp_q.delete();
        exp_q.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, rm, ir));
        if (mov_imm) exp_q.push_back(mk(0, 2'b01, 1, 0, 0, 0, 0, 0, rn, ir));
        if (add_and || cmp) exp_q.push_back(mk(0, 2'b00, 0, 1, 0, 0, 0, 0, rn, ir));
        if (add_and || cmp || mov_reg || mvn) begin
            exp_q.push_back(mk(0, 2'b00, 0, 0, 1, 0, 0, 0, rm, ir));
            exp_q.push_back(mk(0, 2'b00, 0, 0, 0, !cmp, cmp, mov_reg || mvn, rm, ir));
        end
        if (add_and || mov_reg || mvn) exp_q.push_back(mk(0, 2'b11, 1, 0, 0, 0, 0, 0, rd, ir));
    endfunction

    task automatic run_instr(input logic [15:0] instr, input bit junk_load);
        @(negedge clk);
        in_t = instr; load_t = 1'b1; s_t = 1'b1;
        @(posedge clk); #1;
        load_t = junk_load; in_t = ~instr; s_t = 1'b0;
        build(instr);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            check($sformatf("step%0d_%h", i, instr), 32'(observe()), 32'(exp_q[i]));
        end
        @(posedge clk); #1;
        load_t = 1'b0;
        check("wait_ctrl", 32'(observe()), 32'(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, instr[2:0], instr)));
        check("sximm8", 32'(sximm8), 32'({{8{instr[7]}}, instr[7:0]}));
        check("sximm5", 32'(sximm5), 32'({{11{instr[4]}}, instr[4:0]}));
    endtask

    initial begin
        logic [15:0] r;
        reset_n = 1'b0; in_t = 16'h0; load_t = 1'b0; s_t = 1'b0;
        #3;
        check("reset_ctrl", 32'(observe()), 32'(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0)));
        check("reset_ir", 32'(sximm8), 32'h0);
        @(negedge clk); reset_n = 1'b1;

        run_instr(16'hD107, 1'b0);
        run_instr(16'hA148, 1'b0);
        run_instr(16'hA900, 1'b1);
        run_instr(16'hB860, 1'b0);
        run_instr(16'hC008, 1'b1);
        run_instr(16'hD0FF, 1'b0);
        run_instr(16'h0010, 1'b0);
        run_instr(16'hE000, 1'b1);

        // s held high restarts as soon as WAIT is re-entered.
        @(negedge clk); in_t = 16'hD107; load_t = 1'b1; s_t = 1'b1;
        @(posedge clk); #1; load_t = 1'b0;
        check("hold_s_dec", 32'(w), 32'd0);
        repeat (2) @(posedge clk);
        #1 check("hold_s_wait", 32'(w), 32'd1);
        @(posedge clk); #1;
        check("hold_s_restart", 32'(w), 32'd0);
        s_t = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("hold_s_done", 32'(w), 32'd1);

        // Asynchronous reset during GET_B of ADD.
        @(negedge clk); in_t = 16'hA148; load_t = 1'b1; s_t = 1'b1;
        @(posedge clk); #1; load_t = 1'b0; s_t = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("mid_loadb", 32'(loadb), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_w", 32'(w), 32'd1);
        check("mid_rst_loadb", 32'(loadb), 32'd0);
        check("mid_rst_ir", 32'(sximm8), 32'h0);
        @(negedge clk); reset_n = 1'b1;

        for (int n = 0; n < 60; n++) begin
            r = 16'($urandom);
            case ($urandom_range(0, 3))
                0: r[15:13] = 3'b110;
                1, 2: r[15:13] = 3'b101;
                default: ;
            endcase
            run_instr(r, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
